// File: rtl/booth3_seq_mult.sv
// Sequential radix-8 (Booth-3) multiplier: 3A is precomputed once per operation,
// then one Booth digit is accumulated per cycle.
module booth3_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 in_ready,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out
);

  localparam int unsigned N   = (WIDTH + 3) / 3;
  localparam int unsigned BW  = 3 * N;
  localparam int unsigned AW  = WIDTH + 2;
  localparam int unsigned PW  = WIDTH + 3;
  localparam int unsigned OW  = 2 * WIDTH;
  localparam int unsigned KW  = $clog2(N + 1);
  localparam int unsigned SW  = $clog2(3 * N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRECOMP,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   m3_q, m3_d;
  logic [BW:0]     b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic [KW-1:0]   k_q, k_d;
  logic [OW-1:0]   out_q, out_d;

  logic [AW-1:0]   a_ext;
  logic [BW-1:0]   b_ext;
  logic [AW-1:0]   mag;
  logic            neg;
  logic [PW-1:0]   mag_ext;
  logic [PW-1:0]   pp;
  logic [OW-1:0]   pp_wide;
  logic [SW-1:0]   shamt;
  logic [OW-1:0]   acc_sum;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

  always_comb begin
    a_ext = {{2{sgn & in0[WIDTH-1]}}, in0};
    b_ext = {{(BW - WIDTH){sgn & in1[WIDTH-1]}}, in1};
  end

  // b_q[0] holds B[-1]; the register shifts right by 3 per digit so the
  // current window is always b_q[3:0].
  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (b_q[3:0])
      4'b0000, 4'b1111: begin mag = '0;             neg = 1'b0; end
      4'b0001, 4'b0010: begin mag = a_q;            neg = 1'b0; end
      4'b0011, 4'b0100: begin mag = a_q << 1;       neg = 1'b0; end
      4'b0101, 4'b0110: begin mag = m3_q;           neg = 1'b0; end
      4'b0111:          begin mag = a_q << 2;       neg = 1'b0; end
      4'b1000:          begin mag = a_q << 2;       neg = 1'b1; end
      4'b1001, 4'b1010: begin mag = m3_q;           neg = 1'b1; end
      4'b1011, 4'b1100: begin mag = a_q << 1;       neg = 1'b1; end
      default:          begin mag = a_q;            neg = 1'b1; end
    endcase
  end

  // One guard bit above the (WIDTH+2)-bit multiple keeps unsigned 3A/4A
  // exact through negation; extension of that bit follows the latched mode.
  always_comb begin
    mag_ext = {sgn_q & mag[AW-1], mag};
    pp      = neg ? (~mag_ext + 1'b1) : mag_ext;
    pp_wide = {{(OW - PW){pp[PW-1]}}, pp};
    shamt   = SW'(32'd3 * 32'(k_q));
    acc_sum = acc_q + (pp_wide << shamt);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m3_d    = m3_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    k_d     = k_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_ext;
          sgn_d   = sgn;
          b_d     = {b_ext, 1'b0};
          acc_d   = '0;
          k_d     = '0;
          state_d = S_PRECOMP;
        end
      end
      S_PRECOMP: begin
        m3_d    = a_q + (a_q << 1);
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        b_d   = {3'b000, b_q[BW:3]};
        k_d   = k_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          out_d   = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m3_q    <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m3_q    <= m3_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_booth3_seq_mult.sv
// Directed bench for booth3_seq_mult: WIDTH=8 vectors, handshake/reset behaviour,
// and a WIDTH=16 corner and pseudo-random sweep against a reference product.
module tb_booth3_seq_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, sgn8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  logic        start16, sgn16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] out16;

  int n_checks = 0;
  int n_pass   = 0;

  booth3_seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_ready(ir8), .sgn(sgn8),
    .in0(a8), .in1(b8), .out_valid(ov8), .out_ready(or8), .out(out8)
  );

  booth3_seq_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_ready(ir16), .sgn(sgn16),
    .in0(a16), .in1(b16), .out_valid(ov16), .out_ready(or16), .out(out16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic run8(input string tag, input logic s, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    int   cyc;
    logic ir_bad;
    for (int i = 0; i < 20 && !ir8; i++) @(negedge clk);
    start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; sgn8 = ~s; a8 = ~a; b8 = b ^ 8'h5A;
    cyc = 0; ir_bad = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      ir_bad |= ir8;
    end while (!ov8 && cyc < 40);
    check({tag, "_lat"}, 64'(cyc), 64'd5);
    check(tag, 64'(out8), 64'(exp));
    check({tag, "_irdy_low"}, 64'(ir_bad), 64'd0);
    @(negedge clk);
    check({tag, "_bubble"}, 64'({ir8, ov8}), 64'(2'b10));
    check({tag, "_hold"}, 64'(out8), 64'(exp));
  endtask

  task automatic run16(input string tag, input logic s, input logic [15:0] a,
                       input logic [15:0] b);
    int          cyc;
    longint      ra, rb;
    logic [63:0] pv;
    ra = s ? longint'($signed(a)) : longint'(a);
    rb = s ? longint'($signed(b)) : longint'(b);
    pv = 64'(ra * rb);
    for (int i = 0; i < 20 && !ir16; i++) @(negedge clk);
    start16 = 1'b1; sgn16 = s; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~s;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ov16 && cyc < 40);
    check({tag, "_lat"}, 64'(cyc), 64'd8);
    check(tag, 64'(out16), 64'(pv[31:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic        ir_bad, stall_bad;
    logic [15:0] corners [5];
    corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};

    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
    #1;
    check("rst_irdy", 64'(ir8), 64'd1);
    check("rst_ovalid", 64'(ov8), 64'd0);
    check("rst_out8", 64'(out8), 64'd0);
    check("rst_out16", 64'(out16), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run8("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("s_80x7F", 1'b1, 8'h80, 8'h7F, 16'hC080);
    run8("s_FDx05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    run8("u_FFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("u_80x80", 1'b0, 8'h80, 8'h80, 16'h4000);
    run8("u_FFx01", 1'b0, 8'hFF, 8'h01, 16'h00FF);
    run8("s_FFx01", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
    run8("s_7Fx7F", 1'b1, 8'h7F, 8'h7F, 16'h3F01);
    run8("s_FFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    run8("u_00xFF", 1'b0, 8'h00, 8'hFF, 16'h0000);
    run8("u_0Cx0D", 1'b0, 8'h0C, 8'h0D, 16'h009C);
    run8("s_85x3B", 1'b1, 8'h85, 8'h3B, 16'hE3A7);

    // back-pressure with an ignored start during the stall
    or8 = 1'b0;
    for (int i = 0; i < 20 && !ir8; i++) @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ov8 && cyc < 40);
    check("bp_lat", 64'(cyc), 64'd5);
    check("bp_prod", 64'(out8), 64'h03A8);
    stall_bad = 1'b0; ir_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start8 = 1'b1; sgn8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      stall_bad |= (out8 !== 16'h03A8) || !ov8;
      ir_bad    |= ir8;
    end
    start8 = 1'b0;
    check("bp_stable", 64'(stall_bad), 64'd0);
    check("bp_irdy_low", 64'(ir_bad), 64'd0);
    or8 = 1'b1;
    @(negedge clk);
    check("bp_release", 64'({ir8, ov8}), 64'(2'b10));
    check("bp_hold", 64'(out8), 64'h03A8);
    @(negedge clk);
    check("bp_no_ghost", 64'({ir8, ov8}), 64'(2'b10));

    // asynchronous reset in the middle of ACCUM
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'h55; b8 = 8'h66;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out", 64'(out8), 64'd0);
    check("mid_rst_ovalid", 64'(ov8), 64'd0);
    check("mid_rst_irdy", 64'(ir8), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run8("u_3x7_after_rst", 1'b0, 8'h03, 8'h07, 16'h0015);

    for (int unsigned m = 0; m < 2; m++)
      for (int unsigned i = 0; i < 5; i++)
        for (int unsigned j = 0; j < 5; j++)
          run16($sformatf("w16_corner_m%0d_%0d_%0d", m, i, j), m[0], corners[i], corners[j]);
    for (int unsigned r = 0; r < 300; r++)
      run16($sformatf("w16_rand_%0d", r), r[0], 16'($urandom), 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
